// File: rtl/cmplx_pkg.sv
// Shared constants for the complex multiplier scheduler: default operand
// widths, result width derivation and a constant-evaluable clog2.
package cmplx_pkg;

  localparam int DEF_AW = 16;
  localparam int DEF_BW = 16;

  // Smallest component width that holds a full-precision complex product.
  function automatic int min_ow(input int aw, input int bw);
    return aw + bw + 1;
  endfunction

  // Never returns less than 1 so a tag port always exists.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: the first asserted request at or after ptr_i
// (wrapping modulo N) wins; the pointer itself is owned by the caller.
module rr_arbiter
  import cmplx_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          en_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o
);

  logic          found;
  logic [IW-1:0] pos;
  int            j;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    pos     = '0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      pos = IW'(j);
      if (!found && req_i[pos]) begin
        found = 1'b1;
        idx_o = pos;
      end
    end
    // idx_o is still reported when disabled; only the grant is gated.
    if (en_i && found) grant_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/complex_mult_sched.sv
// Round-robin sharing of one 3-stage full-precision complex multiplier
// among N_REQ requesters; results leave in grant order tagged with the source.
module complex_mult_sched
  import cmplx_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int AW    = DEF_AW,
  parameter  int BW    = DEF_BW,
  parameter  int OW    = min_ow(AW, BW),
  localparam int IDW   = clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*AW-1:0] req_a_re,
  input  logic [N_REQ*AW-1:0] req_a_im,
  input  logic [N_REQ*BW-1:0] req_b_re,
  input  logic [N_REQ*BW-1:0] req_b_im,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [OW-1:0]       res_re,
  output logic [OW-1:0]       res_im,
  output logic [IDW-1:0]      res_id,
  output logic                busy
);

  localparam int PW = AW + BW;

  if (OW < PW + 1) begin : g_bad_ow
    $error("complex_mult_sched: OW must be at least AW+BW+1");
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1. Requesters hold valid and operands until accepted; req_ready never
  // looks at operand values. The result side holds res_* while res_ready=0.

  function automatic logic signed [PW-1:0] mul(input logic signed [AW-1:0] a,
                                               input logic signed [BW-1:0] b);
    return $signed({{BW{a[AW-1]}}, a}) * $signed({{AW{b[BW-1]}}, b});
  endfunction

  function automatic logic signed [OW-1:0] sext(input logic signed [PW-1:0] p);
    return {{(OW-PW){p[PW-1]}}, p};
  endfunction

  logic                 advance;
  logic                 hs;
  logic [N_REQ-1:0]     grant;
  logic [IDW-1:0]       g_idx;
  logic [IDW-1:0]       ptr_q, ptr_d;

  logic [AW-1:0]        sel_a_re, sel_a_im;
  logic [BW-1:0]        sel_b_re, sel_b_im;

  logic                 s1_v_q, s1_v_d;
  logic signed [AW-1:0] s1_a_re_q, s1_a_re_d, s1_a_im_q, s1_a_im_d;
  logic signed [BW-1:0] s1_b_re_q, s1_b_re_d, s1_b_im_q, s1_b_im_d;
  logic [IDW-1:0]       s1_id_q, s1_id_d;

  logic                 s2_v_q, s2_v_d;
  logic signed [PW-1:0] s2_rr_q, s2_rr_d, s2_ii_q, s2_ii_d;
  logic signed [PW-1:0] s2_ir_q, s2_ir_d, s2_ri_q, s2_ri_d;
  logic [IDW-1:0]       s2_id_q, s2_id_d;

  logic                 s3_v_q, s3_v_d;
  logic signed [OW-1:0] s3_re_q, s3_re_d, s3_im_q, s3_im_d;
  logic [IDW-1:0]       s3_id_q, s3_id_d;

  // One shared stall: the whole pipe moves only when the output slot frees up.
  assign advance = !s3_v_q || res_ready;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IDW)
  ) u_arb (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .en_i    (advance && !rst),
    .grant_o (grant),
    .idx_o   (g_idx)
  );

  assign req_ready = grant;
  assign hs        = |grant;

  assign sel_a_re = req_a_re[g_idx*AW +: AW];
  assign sel_a_im = req_a_im[g_idx*AW +: AW];
  assign sel_b_re = req_b_re[g_idx*BW +: BW];
  assign sel_b_im = req_b_im[g_idx*BW +: BW];

  always_comb begin
    ptr_d = ptr_q;
    if (hs) ptr_d = (g_idx == IDW'(N_REQ - 1)) ? '0 : g_idx + 1'b1;
  end

  always_comb begin
    s1_v_d    = s1_v_q;
    s1_a_re_d = s1_a_re_q;
    s1_a_im_d = s1_a_im_q;
    s1_b_re_d = s1_b_re_q;
    s1_b_im_d = s1_b_im_q;
    s1_id_d   = s1_id_q;
    s2_v_d    = s2_v_q;
    s2_rr_d   = s2_rr_q;
    s2_ii_d   = s2_ii_q;
    s2_ir_d   = s2_ir_q;
    s2_ri_d   = s2_ri_q;
    s2_id_d   = s2_id_q;
    s3_v_d    = s3_v_q;
    s3_re_d   = s3_re_q;
    s3_im_d   = s3_im_q;
    s3_id_d   = s3_id_q;
    if (advance) begin
      s1_v_d = hs;
      if (hs) begin
        s1_a_re_d = sel_a_re;
        s1_a_im_d = sel_a_im;
        s1_b_re_d = sel_b_re;
        s1_b_im_d = sel_b_im;
        s1_id_d   = g_idx;
      end
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_rr_d = mul(s1_a_re_q, s1_b_re_q);
        s2_ii_d = mul(s1_a_im_q, s1_b_im_q);
        s2_ir_d = mul(s1_a_im_q, s1_b_re_q);
        s2_ri_d = mul(s1_a_re_q, s1_b_im_q);
        s2_id_d = s1_id_q;
      end
      // Data registers only load behind a valid item, so the last result stays visible.
      s3_v_d = s2_v_q;
      if (s2_v_q) begin
        s3_re_d = sext(s2_rr_q) - sext(s2_ii_q);
        s3_im_d = sext(s2_ir_q) + sext(s2_ri_q);
        s3_id_d = s2_id_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      s1_v_q    <= 1'b0;
      s1_a_re_q <= '0;
      s1_a_im_q <= '0;
      s1_b_re_q <= '0;
      s1_b_im_q <= '0;
      s1_id_q   <= '0;
      s2_v_q    <= 1'b0;
      s2_rr_q   <= '0;
      s2_ii_q   <= '0;
      s2_ir_q   <= '0;
      s2_ri_q   <= '0;
      s2_id_q   <= '0;
      s3_v_q    <= 1'b0;
      s3_re_q   <= '0;
      s3_im_q   <= '0;
      s3_id_q   <= '0;
    end else begin
      ptr_q     <= ptr_d;
      s1_v_q    <= s1_v_d;
      s1_a_re_q <= s1_a_re_d;
      s1_a_im_q <= s1_a_im_d;
      s1_b_re_q <= s1_b_re_d;
      s1_b_im_q <= s1_b_im_d;
      s1_id_q   <= s1_id_d;
      s2_v_q    <= s2_v_d;
      s2_rr_q   <= s2_rr_d;
      s2_ii_q   <= s2_ii_d;
      s2_ir_q   <= s2_ir_d;
      s2_ri_q   <= s2_ri_d;
      s2_id_q   <= s2_id_d;
      s3_v_q    <= s3_v_d;
      s3_re_q   <= s3_re_d;
      s3_im_q   <= s3_im_d;
      s3_id_q   <= s3_id_d;
    end
  end

  assign res_valid = s3_v_q;
  assign res_re    = s3_re_q;
  assign res_im    = s3_im_q;
  assign res_id    = s3_id_q;
  assign busy      = s1_v_q || s2_v_q || s3_v_q;

endmodule
